// File: rtl/fpu_apu_dispatch.sv
// fpu_apu_dispatch: core-side APU initiator; tags FPU ops, issues them downstream, collects tagged results.
// Core side:   Req_SI/Gnt_SO with OpA_DI, OpB_DI, Op_SI, RM_SI, Id_DI
// Downstream:  Valid_SO/Ready_SI with ArgA_DO, ArgB_DO, Op_SO, Flags_SO (rounding mode), Tag_SO
// Upstream:    ResValid_SI (no ready) with Result_DI, ResFlags_DI, ResTag_DI
// Response:    RespValid_SO/RespReady_SI with RespData_DO, RespFlags_DO, RespId_DO
// Status:      Busy_SO (tags in use or responses pending), Error_SO (sticky bad tag / overflow)
module fpu_apu_dispatch #(
    parameter int OP_W      = 32,
    parameter int CMD_W     = 4,
    parameter int RM_W      = 3,
    parameter int FLAG_W    = 9,
    parameter int TAG_W     = 2,
    parameter int ID_W      = 5,
    parameter int RES_DEPTH = 4
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic              Req_SI,
    output logic              Gnt_SO,
    input  logic [OP_W-1:0]   OpA_DI,
    input  logic [OP_W-1:0]   OpB_DI,
    input  logic [CMD_W-1:0]  Op_SI,
    input  logic [RM_W-1:0]   RM_SI,
    input  logic [ID_W-1:0]   Id_DI,
    output logic              Valid_SO,
    input  logic              Ready_SI,
    output logic [OP_W-1:0]   ArgA_DO,
    output logic [OP_W-1:0]   ArgB_DO,
    output logic [CMD_W-1:0]  Op_SO,
    output logic [RM_W-1:0]   Flags_SO,
    output logic [TAG_W-1:0]  Tag_SO,
    input  logic              ResValid_SI,
    input  logic [OP_W-1:0]   Result_DI,
    input  logic [FLAG_W-1:0] ResFlags_DI,
    input  logic [TAG_W-1:0]  ResTag_DI,
    output logic              RespValid_SO,
    input  logic              RespReady_SI,
    output logic [OP_W-1:0]   RespData_DO,
    output logic [FLAG_W-1:0] RespFlags_DO,
    output logic [ID_W-1:0]   RespId_DO,
    output logic              Busy_SO,
    output logic              Error_SO
);
    localparam int NT = 1 << TAG_W;
    localparam int PW = RES_DEPTH > 1 ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int FW = OP_W + FLAG_W + ID_W;

    logic [NT-1:0]   in_use;
    logic [ID_W-1:0] id_tab [NT];
    logic [FW-1:0]   mem [RES_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic [TAG_W:0]  in_flight;
    logic [TAG_W-1:0] free_tag;
    logic            free, credit, hit, pop, full, push, ovf, err;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(RES_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Scanning downward leaves the lowest-index free tag as the final pick.
    always_comb begin
        in_flight = '0;
        free      = 1'b0;
        free_tag  = '0;
        for (int i = NT - 1; i >= 0; i--) begin
            in_flight = in_flight + (TAG_W + 1)'(in_use[i]);
            if (!in_use[i]) begin
                free     = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    // A credit is only returned once a response leaves the FIFO, so every
    // outstanding result is guaranteed a FIFO slot.
    assign credit       = 32'(in_flight) + 32'(fifo_cnt) < 32'(RES_DEPTH);
    assign Gnt_SO       = Req_SI & free & credit & (~Valid_SO | Ready_SI);
    assign hit          = ResValid_SI & in_use[ResTag_DI];
    assign pop          = RespValid_SO & RespReady_SI;
    assign full         = fifo_cnt == CW'(RES_DEPTH);
    assign push         = hit & (~full | pop);
    assign ovf          = hit & full & ~pop;
    assign RespValid_SO = fifo_cnt != '0;
    assign Busy_SO      = (|in_use) | RespValid_SO;
    assign Error_SO     = err;
    assign {RespData_DO, RespFlags_DO, RespId_DO} = mem[rd_ptr];

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            in_use   <= '0;
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            err      <= 1'b0;
            Valid_SO <= 1'b0;
            ArgA_DO  <= '0;
            ArgB_DO  <= '0;
            Op_SO    <= '0;
            Flags_SO <= '0;
            Tag_SO   <= '0;
            for (int i = 0; i < RES_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (Gnt_SO) begin
                in_use[free_tag] <= 1'b1;
                id_tab[free_tag] <= Id_DI;
                Valid_SO         <= 1'b1;
                ArgA_DO          <= OpA_DI;
                ArgB_DO          <= OpB_DI;
                Op_SO            <= Op_SI;
                Flags_SO         <= RM_SI;
                Tag_SO           <= free_tag;
            end else if (Ready_SI) begin
                Valid_SO <= 1'b0;
            end
            // A granted tag is never the returning one: grants pick free tags, hits need used ones.
            if (hit) in_use[ResTag_DI] <= 1'b0;
            if ((ResValid_SI & ~in_use[ResTag_DI]) | ovf) err <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= {Result_DI, ResFlags_DI, id_tab[ResTag_DI]};
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end
endmodule
